// File: rtl/ex_mem_stage_pkg.sv
// Shared encodings for the execute stage: ALU operations, funct codes,
// ALU-op classes from decode, and operand forwarding selects.
package ex_mem_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// Execute-stage bundle: ID/EX fields, hazard/writeback side inputs and the
// EX/MEM register outputs. master drives ID/EX, slave is the execute stage.
interface ex_mem_stage_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             regdst, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite;
  logic [1:0]       aluop;
  logic [WIDTH-1:0] read1, read2, signExtended, pc4;
  logic [REGW-1:0]  ins25_21, ins20_16, ins15_11;
  logic [REGW-1:0]  ifid_rs, ifid_rt;
  logic             memwb_regwrite;
  logic [REGW-1:0]  memwb_rd;
  logic [WIDTH-1:0] memwb_data;
  logic             stall, flush;
  logic             load_use;
  logic             mem_valid, mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite;
  logic             mem_branch, mem_jump, mem_zero;
  logic [WIDTH-1:0] mem_aluresult, mem_writedata, mem_target;
  logic [REGW-1:0]  mem_rd;

  modport master (
    output regdst, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop,
           read1, read2, signExtended, pc4, ins25_21, ins20_16, ins15_11,
           ifid_rs, ifid_rt, memwb_regwrite, memwb_rd, memwb_data, stall, flush,
    input  load_use, mem_valid, mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite,
           mem_branch, mem_jump, mem_zero, mem_aluresult, mem_writedata, mem_target, mem_rd
  );

  modport slave (
    input  regdst, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop,
           read1, read2, signExtended, pc4, ins25_21, ins20_16, ins15_11,
           ifid_rs, ifid_rt, memwb_regwrite, memwb_rd, memwb_data, stall, flush,
    output load_use, mem_valid, mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite,
           mem_branch, mem_jump, mem_zero, mem_aluresult, mem_writedata, mem_target, mem_rd
  );
endinterface

// File: rtl/ex_mem_stage_alu_ctrl.sv
// ALU control: maps the decode op class plus funct field to an ALU operation.
module ex_mem_stage_alu_ctrl
  import ex_mem_stage_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output alu_op_t    op
);

  always_comb begin
    op = ALU_ADD;
    case (aluop)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_AND: op = ALU_AND;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: op = ALU_ADD;
          FUNCT_SUB: op = ALU_SUB;
          FUNCT_AND: op = ALU_AND;
          FUNCT_OR:  op = ALU_OR;
          FUNCT_SLT: op = ALU_SLT;
          default:   op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage of the 5-stage MIPS pipeline: forwarding, ALU, branch target,
// EX/MEM register and the load-use hazard flag.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input logic          clk,
  input logic          startin,
  ex_mem_stage_if.slave bus
);

  logic             vld_p1, regwrite_p1, memtoreg_p1, memread_p1, memwrite_p1;
  logic             branch_p1, jump_p1, zero_p1;
  logic [WIDTH-1:0] aluresult_p1, writedata_p1, target_p1;
  logic [REGW-1:0]  rd_p1;

  fwd_sel_t         sel_a, sel_b;
  alu_op_t          alu_op;
  logic [WIDTH-1:0] fwd_a, fwd_b, alu_b, alu_res, target;
  logic [REGW-1:0]  dst;

  function automatic fwd_sel_t fwd_pick(
    input logic [REGW-1:0] src,
    input logic            ex_en,
    input logic [REGW-1:0] ex_rd,
    input logic            wb_en,
    input logic [REGW-1:0] wb_rd
  );
    if (ex_en && ex_rd != '0 && ex_rd == src)
      return FWD_EXMEM;
    else if (wb_en && wb_rd != '0 && wb_rd == src)
      return FWD_MEMWB;
    else
      return FWD_REG;
  endfunction

  function automatic logic [WIDTH-1:0] alu_eval(
    input alu_op_t                 op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (op)
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = a + b;
    endcase
    return r;
  endfunction

  ex_mem_stage_alu_ctrl u_alu_ctrl (
    .aluop (bus.aluop),
    .funct (bus.signExtended[5:0]),
    .op    (alu_op)
  );

  // Stage p0: operand forwarding and execute. A bubble in EX/MEM never forwards.
  always_comb begin
    sel_a = fwd_pick(bus.ins25_21, vld_p1 && regwrite_p1, rd_p1, bus.memwb_regwrite, bus.memwb_rd);
    sel_b = fwd_pick(bus.ins20_16, vld_p1 && regwrite_p1, rd_p1, bus.memwb_regwrite, bus.memwb_rd);

    case (sel_a)
      FWD_EXMEM: fwd_a = aluresult_p1;
      FWD_MEMWB: fwd_a = bus.memwb_data;
      default:   fwd_a = bus.read1;
    endcase

    case (sel_b)
      FWD_EXMEM: fwd_b = aluresult_p1;
      FWD_MEMWB: fwd_b = bus.memwb_data;
      default:   fwd_b = bus.read2;
    endcase

    alu_b   = bus.alusrc ? bus.signExtended : fwd_b;
    alu_res = alu_eval(alu_op, fwd_a, alu_b);
    target  = bus.pc4 + {bus.signExtended[WIDTH-3:0], 2'b00};
    dst     = bus.regdst ? bus.ins15_11 : bus.ins20_16;
  end

  assign bus.load_use = bus.memread && (bus.ins20_16 != '0) &&
                        ((bus.ins20_16 == bus.ifid_rs) || (bus.ins20_16 == bus.ifid_rt));

  // Stage p1: EX/MEM register. Reset and flush both leave a zeroed bubble.
  always_ff @(posedge clk) begin
    if (!startin || bus.flush) begin
      vld_p1       <= 1'b0;
      regwrite_p1  <= 1'b0;
      memtoreg_p1  <= 1'b0;
      memread_p1   <= 1'b0;
      memwrite_p1  <= 1'b0;
      branch_p1    <= 1'b0;
      jump_p1      <= 1'b0;
      zero_p1      <= 1'b0;
      aluresult_p1 <= '0;
      writedata_p1 <= '0;
      target_p1    <= '0;
      rd_p1        <= '0;
    end else if (!bus.stall) begin
      vld_p1       <= 1'b1;
      regwrite_p1  <= bus.regwrite;
      memtoreg_p1  <= bus.memtoreg;
      memread_p1   <= bus.memread;
      memwrite_p1  <= bus.memwrite;
      branch_p1    <= bus.branch;
      jump_p1      <= bus.jump;
      zero_p1      <= (alu_res == '0);
      aluresult_p1 <= alu_res;
      writedata_p1 <= fwd_b;
      target_p1    <= target;
      rd_p1        <= dst;
    end
  end

  assign bus.mem_valid     = vld_p1;
  assign bus.mem_regwrite  = regwrite_p1;
  assign bus.mem_memtoreg  = memtoreg_p1;
  assign bus.mem_memread   = memread_p1;
  assign bus.mem_memwrite  = memwrite_p1;
  assign bus.mem_branch    = branch_p1;
  assign bus.mem_jump      = jump_p1;
  assign bus.mem_zero      = zero_p1;
  assign bus.mem_aluresult = aluresult_p1;
  assign bus.mem_writedata = writedata_p1;
  assign bus.mem_target    = target_p1;
  assign bus.mem_rd        = rd_p1;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, ALU ops, forwarding, load-use,
// stall/flush and branch target, with hand-computed expectations.
module tb_ex_mem_stage;
  localparam int WIDTH = 32;
  localparam int REGW  = 5;

  logic clk = 1'b0;
  logic startin;
  always #5 clk = ~clk;

  ex_mem_stage_if #(.WIDTH(WIDTH), .REGW(REGW)) bus ();
  ex_mem_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (.clk(clk), .startin(startin), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  // {regwrite, memtoreg, memread, memwrite, branch, jump, zero}
  function automatic logic [31:0] ctrl();
    return {25'd0, bus.mem_regwrite, bus.mem_memtoreg, bus.mem_memread, bus.mem_memwrite,
            bus.mem_branch, bus.mem_jump, bus.mem_zero};
  endfunction

  task automatic check_regs(input string tag, input logic vld, input logic [6:0] c,
                            input logic [31:0] res, input logic [31:0] wd,
                            input logic [31:0] tgt, input logic [4:0] rd);
    check({tag, ".valid"}, {31'd0, bus.mem_valid}, {31'd0, vld});
    check({tag, ".ctrl"}, ctrl(), {25'd0, c});
    check({tag, ".result"}, bus.mem_aluresult, res);
    check({tag, ".wdata"}, bus.mem_writedata, wd);
    check({tag, ".target"}, bus.mem_target, tgt);
    check({tag, ".rd"}, {27'd0, bus.mem_rd}, {27'd0, rd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {bus.regdst, bus.jump, bus.branch, bus.memread, bus.memtoreg,
     bus.memwrite, bus.alusrc, bus.regwrite} = '0;
    bus.aluop = 2'b00;
    bus.read1 = '0; bus.read2 = '0; bus.signExtended = '0; bus.pc4 = '0;
    bus.ins25_21 = '0; bus.ins20_16 = '0; bus.ins15_11 = '0;
    bus.ifid_rs = '0; bus.ifid_rt = '0;
    bus.memwb_regwrite = 1'b0; bus.memwb_rd = '0; bus.memwb_data = '0;
    bus.stall = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic op_f();
    idle();
    bus.regwrite = 1'b1; bus.memread = 1'b1; bus.memtoreg = 1'b1;
    bus.ins20_16 = 5'd3; bus.aluop = 2'b00; bus.alusrc = 1'b1;
    bus.read1 = 32'h40; bus.read2 = 32'h55; bus.signExtended = 32'h8; bus.pc4 = 32'h10;
  endtask

  initial begin
    // Reset with random inputs
    startin = 1'b0;
    {bus.regdst, bus.jump, bus.branch, bus.memread, bus.memtoreg,
     bus.memwrite, bus.alusrc, bus.regwrite} = 8'($urandom);
    bus.aluop = 2'($urandom);
    bus.read1 = $urandom; bus.read2 = $urandom; bus.signExtended = $urandom; bus.pc4 = $urandom;
    bus.ins25_21 = 5'($urandom); bus.ins20_16 = 5'($urandom); bus.ins15_11 = 5'($urandom);
    bus.ifid_rs = 5'($urandom); bus.ifid_rt = 5'($urandom);
    bus.memwb_regwrite = 1'($urandom); bus.memwb_rd = 5'($urandom); bus.memwb_data = $urandom;
    bus.stall = 1'b0; bus.flush = 1'b0;
    tick(); tick();
    check_regs("reset", 1'b0, 7'b0, 32'h0, 32'h0, 32'h0, 5'd0);

    // R-type SUB, loaded on the first edge after reset release
    startin = 1'b1;
    idle();
    bus.regwrite = 1'b1; bus.regdst = 1'b1; bus.aluop = 2'b10; bus.signExtended = 32'h22;
    bus.read1 = 32'd8; bus.read2 = 32'd10; bus.ins25_21 = 5'd1; bus.ins20_16 = 5'd2;
    bus.ins15_11 = 5'd5;
    tick();
    check_regs("sub", 1'b1, 7'b1000000, 32'hFFFF_FFFE, 32'd10, 32'h88, 5'd5);

    bus.signExtended = 32'h2A;
    tick();
    check("slt", bus.mem_aluresult, 32'd1);
    check("slt.zero", {31'd0, bus.mem_zero}, 32'd0);

    bus.read1 = 32'hFFFF_FFFB; bus.read2 = 32'd3;
    tick();
    check("slt.signed", bus.mem_aluresult, 32'd1);

    bus.read1 = 32'hC; bus.read2 = 32'hA; bus.signExtended = 32'h25;
    tick();
    check("or", bus.mem_aluresult, 32'hE);
    bus.signExtended = 32'h24;
    tick();
    check("and", bus.mem_aluresult, 32'h8);
    bus.signExtended = 32'h3F;
    tick();
    check("funct.default", bus.mem_aluresult, 32'h16);

    // Forwarding
    idle();
    bus.regwrite = 1'b1; bus.regdst = 1'b1; bus.ins15_11 = 5'd4;
    bus.alusrc = 1'b1; bus.read1 = 32'd20; bus.signExtended = 32'd5;
    tick();
    check("fwd.setup", bus.mem_aluresult, 32'd25);

    idle();
    bus.regwrite = 1'b1; bus.regdst = 1'b1; bus.ins15_11 = 5'd0;
    bus.ins25_21 = 5'd4; bus.alusrc = 1'b1; bus.signExtended = 32'd1; bus.read1 = 32'd1000;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd4; bus.memwb_data = 32'd99;
    tick();
    check("fwd.exmem_wins", bus.mem_aluresult, 32'd26);

    tick();
    check("fwd.memwb", bus.mem_aluresult, 32'd100);

    bus.ins25_21 = 5'd0; bus.memwb_rd = 5'd0;
    bus.regdst = 1'b0; bus.ins20_16 = 5'd0;
    tick();
    check("fwd.reg0", bus.mem_aluresult, 32'd1001);

    // Last op writes r6 so the next op forwards on rt
    bus.ins20_16 = 5'd6; bus.read2 = 32'd77;
    tick();
    check("fwd.rd6", bus.mem_aluresult, 32'd1001);
    idle();
    bus.alusrc = 1'b0; bus.read1 = 32'd1; bus.ins20_16 = 5'd6; bus.read2 = 32'd7;
    tick();
    check("fwd.b.result", bus.mem_aluresult, 32'd1002);
    check("fwd.b.wdata", bus.mem_writedata, 32'd1001);

    // Load-use (combinational)
    idle();
    bus.memread = 1'b1; bus.ins20_16 = 5'd7; bus.ifid_rt = 5'd7; bus.ifid_rs = 5'd3;
    #1 check("lu.rt", {31'd0, bus.load_use}, 32'd1);
    bus.ins20_16 = 5'd9; bus.ifid_rs = 5'd9;
    #1 check("lu.rs", {31'd0, bus.load_use}, 32'd1);
    bus.ins20_16 = 5'd0; bus.ifid_rt = 5'd0; bus.ifid_rs = 5'd0;
    #1 check("lu.r0", {31'd0, bus.load_use}, 32'd0);
    bus.memread = 1'b0; bus.ins20_16 = 5'd7; bus.ifid_rt = 5'd7;
    #1 check("lu.nomem", {31'd0, bus.load_use}, 32'd0);
    tick();

    // Flush beats stall
    op_f();
    tick();
    check_regs("opf", 1'b1, 7'b1110000, 32'h48, 32'h55, 32'h30, 5'd3);
    bus.stall = 1'b1; bus.flush = 1'b1;
    tick();
    check_regs("flush", 1'b0, 7'b0, 32'h0, 32'h0, 32'h0, 5'd0);

    // Stall holds for three cycles while inputs change
    op_f();
    tick();
    bus.stall = 1'b1; bus.read1 = 32'h999; bus.read2 = 32'h111; bus.pc4 = 32'h500;
    bus.ins20_16 = 5'd9; bus.memread = 1'b0; bus.branch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_regs($sformatf("stall%0d", i), 1'b1, 7'b1110000, 32'h48, 32'h55, 32'h30, 5'd3);
    end

    // Branch target with negative offset
    idle();
    bus.pc4 = 32'h100; bus.signExtended = 32'hFFFF_FFFF; bus.branch = 1'b1;
    bus.aluop = 2'b01; bus.read1 = 32'd3; bus.read2 = 32'd3;
    tick();
    check_regs("branch", 1'b1, 7'b0000101, 32'h0, 32'd3, 32'hFC, 5'd0);

    // Reset mid-run clears everything
    startin = 1'b0;
    tick();
    check_regs("reset2", 1'b0, 7'b0, 32'h0, 32'h0, 32'h0, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
